if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 208 ++++++++++++++++++++
 tb/tb_if_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Fetches one word per cycle from a same-cycle-response instruction memory.
// A stall that arrives together with a memory response parks the word in a
// one-entry pend buffer so the response is not lost. A redirect from a
// resolved branch overrides everything else in that cycle.
//
// Build option:
//   IF_FETCH_COUNT_EN -- adds the fetch_count output, which counts every
//                        valid instruction delivered into IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;  // first cycle after reset, no request
    localparam logic [1:0] ST_REQ  = 2'd1;  // request outstanding at pc
    localparam logic [1:0] ST_PEND = 2'd2;  // word captured under stall, waiting

    // The low two bits of every fetch address are forced to zero, including
    // the reset vector, so pc is always word aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pend;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // Per-cycle action decode; at most one of these is high in any cycle.
    logic        redirect;
    logic        deliver_rdata;
    logic        deliver_pend;
    logic        capture_pend;
    logic        insert_bubble;
    logic        deliver;

    // ------------------------------------------------------------------
    // Address arithmetic
    // ------------------------------------------------------------------
    // The 32-bit add wraps naturally, so 32'hFFFF_FFFC + 4 becomes 0.
    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = {branch_target[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Memory interface
    // ------------------------------------------------------------------
    // A request is issued only from REQ; imem_addr is pc, which does not move
    // while a request waits for imem_ready unless a redirect occurs.
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    // Decode what this cycle does to pc, pend and IF/ID; redirect wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block leaves it unassigned (which infers a latch).
        redirect      = 1'b0;
        deliver_rdata = 1'b0;
        deliver_pend  = 1'b0;
        capture_pend  = 1'b0;
        insert_bubble = 1'b0;

        if (branch_taken) begin
            redirect = 1'b1;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ready && !stall) begin
                        deliver_rdata = 1'b1;
                    end else if (imem_ready && stall) begin
                        capture_pend = 1'b1;
                    end else if (!imem_ready && !stall) begin
                        insert_bubble = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!stall) begin
                        deliver_pend = 1'b1;
                    end
                end
                default: begin
                    // IDLE performs no fetch-side action.
                end
            endcase
        end
    end

    assign deliver = deliver_rdata | deliver_pend;

    // Choose the next FSM state from the decoded action.
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = ST_REQ;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ:  if (capture_pend) state_next = ST_PEND;
                ST_PEND: if (deliver_pend) state_next = ST_REQ;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter: jump on redirect, advance on each delivered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC_ALIGNED;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (deliver) begin
            pc <= pc_plus4;
        end
    end

    // Pend buffer: holds a word that arrived while decode was stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 32'h0;
        end else if (redirect) begin
            pend <= 32'h0;
        end else if (capture_pend) begin
            pend <= imem_rdata;
        end
    end

    // IF/ID register: load a word, insert a bubble, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instruction <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
            if_id_valid       <= 1'b0;
        end else if (redirect || insert_bubble) begin
            // The address half is left as-is; with valid low it is ignored.
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
        end else if (deliver_rdata) begin
            if_id_instruction <= imem_rdata;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
        end else if (deliver_pend) begin
            if_id_instruction <= pend;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    // Count every valid instruction delivered into IF/ID; wraps at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
        end else if (deliver) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // ------------------------------------------------------------------
    // Structural sanity properties
    // ------------------------------------------------------------------
    a_pc_aligned : assert property (@(posedge clk) disable iff (rst)
        pc[1:0] == 2'b00);

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        state != 2'd3);

    a_addr_stable : assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ready && !branch_taken) |=> $stable(imem_addr));

    a_one_action : assert property (@(posedge clk) disable iff (rst)
        $onehot0({redirect, deliver_rdata, deliver_pend, capture_pend, insert_bubble}));
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- self-checking bench for if_stage.
// Directed scenarios plus a randomized run against a behavioural model that
// describes the fetch stage as "pc, an optional held word, and the IF/ID
// contents" updated by the fetch rules.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count       (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    bit          m_started;     // false only during the first cycle after reset
    logic [31:0] m_held[$];     // word fetched while decode was stalled
    logic [31:0] m_count;

    function automatic void model_reset();
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_started = 1'b0;
        m_held.delete();
        m_count   = 32'h0;
    endfunction

    function automatic void model_deliver(input logic [31:0] word);
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
    endfunction

    // One clock edge worth of fetch rules, using the inputs now applied.
    function automatic void model_step();
        if (branch_taken) begin
            m_pc      = branch_target & 32'hFFFF_FFFC;
            m_valid   = 1'b0;
            m_instr   = 32'h0;
            m_started = 1'b1;
            m_held.delete();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_held.size() != 0) begin
            if (!stall) model_deliver(m_held.pop_front());
        end else if (imem_ready && !stall) begin
            model_deliver(imem_rdata);
        end else if (imem_ready && stall) begin
            m_held.push_back(imem_rdata);
        end else if (!imem_ready && !stall) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // ------------------------------------------------------------------
    task automatic drive(input logic s, input logic b, input logic [31:0] t,
                         input logic r, input logic [31:0] d);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_ready    = r;
        imem_rdata    = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        @(posedge clk);
        #1;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        n_tests++; if (if_id_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", if_id_instruction); end
        n_tests++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc_plus4); end
`ifdef IF_FETCH_COUNT_EN
        n_tests++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        // First cycle after release: IDLE, no request.
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        tick();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", imem_req); end
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_load got=%b exp=0", if_id_valid); end
    endtask

    task automatic test_sequential();
        apply_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000);
        tick(); // IDLE -> REQ
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + k);
            n_tests++; if (imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr%0d got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
            tick();
            n_tests++; if (if_id_pc_plus4 !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL seq_pc4_%0d got=%h exp=%h", k, if_id_pc_plus4, 32'(4 * (k + 1))); end
            n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got=%b exp=1", k, if_id_valid); end
            n_tests++; if (if_id_instruction !== 32'hA000_0000 + k) begin n_fail++; $display("FAIL seq_instr%0d got=%h exp=%h", k, if_id_instruction, 32'hA000_0000 + k); end
        end
`ifdef IF_FETCH_COUNT_EN
        n_tests++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
`endif
    endtask

    task automatic test_ready_low();
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'hFFFF_0000);
        tick();
        n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL rl_branch_pc got=%h exp=10", pc); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
            n_tests++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rl_addr%0d got=%h/%b exp=10/1", k, imem_addr, imem_req); end
            tick();
            n_tests++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin n_fail++; $display("FAIL rl_bubble%0d got=%b/%h exp=0/0", k, if_id_valid, if_id_instruction); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1234);
        tick();
        n_tests++; if (if_id_instruction !== 32'h1234 || if_id_pc_plus4 !== 32'h14 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL rl_capture got=%h/%h/%b exp=1234/14/1", if_id_instruction, if_id_pc_plus4, if_id_valid); end
        n_tests++; if (pc !== 32'h14) begin n_fail++; $display("FAIL rl_pc got=%h exp=14", pc); end
    endtask

    task automatic test_stall_pend();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8C22_0004);
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL sp_pend_req got=%b exp=0", imem_req); end
        n_tests++; if (if_id_instruction !== 32'h1234 || if_id_pc_plus4 !== 32'h14 || pc !== 32'h14) begin
            n_fail++; $display("FAIL sp_hold got=%h/%h/%h exp=1234/14/14", if_id_instruction, if_id_pc_plus4, pc); end
        // Still stalled; a stray ready in PEND must be ignored.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        n_tests++; if (if_id_instruction !== 32'h1234 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL sp_hold2 got=%h/%b exp=1234/0", if_id_instruction, imem_req); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        n_tests++; if (if_id_instruction !== 32'h8C22_0004 || if_id_pc_plus4 !== 32'h18 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL sp_release got=%h/%h/%b exp=8c220004/18/1", if_id_instruction, if_id_pc_plus4, if_id_valid); end
        n_tests++; if (pc !== 32'h18 || imem_req !== 1'b1) begin n_fail++; $display("FAIL sp_resume got=%h/%b exp=18/1", pc, imem_req); end
    endtask

    task automatic test_branch_priority();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_0001);
        tick(); // now PEND with a held word
        drive(1'b1, 1'b1, 32'h0000_0043, 1'b1, 32'h6666_6666);
        tick();
        n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_pc got=%h exp=40", pc); end
        n_tests++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin n_fail++; $display("FAIL br_flush got=%b/%h exp=0/0", if_id_valid, if_id_instruction); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_req got=%b/%h exp=1/40", imem_req, imem_addr); end
        // Discarded pend word must not reappear.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        n_tests++; if (if_id_valid !== 1'b0 || pc !== 32'h40) begin n_fail++; $display("FAIL br_discard got=%b/%h exp=0/40", if_id_valid, pc); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_7777);
        tick();
        n_tests++; if (if_id_instruction !== 32'h7777_7777 || if_id_pc_plus4 !== 32'h44) begin
            n_fail++; $display("FAIL br_fetch got=%h/%h exp=77777777/44", if_id_instruction, if_id_pc_plus4); end
    endtask

    task automatic test_wrap();
        logic [31:0] count_before;
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
        tick();
        n_tests++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_pc got=%h exp=fffffffc", pc); end
        count_before = m_count;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
        tick();
        n_tests++; if (pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL wr_wrap got=%h/%h/%b exp=0/0/1", pc, if_id_pc_plus4, if_id_valid); end
`ifdef IF_FETCH_COUNT_EN
        n_tests++; if (fetch_count !== count_before + 32'd1) begin n_fail++; $display("FAIL wr_count got=%0d exp=%0d", fetch_count, count_before + 32'd1); end
`endif
    endtask

    task automatic test_reset_midop();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0001);
        tick(); // PEND with a held word
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 32'h0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rm_async got=%h/%b/%h/%h/%b exp=0/0/0/0/0", pc, if_id_valid, if_id_instruction, if_id_pc_plus4, imem_req); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0002);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        tick(); // IDLE -> REQ, nothing delivered
        n_tests++; if (if_id_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL rm_abandon got=%b/%h/%b exp=0/0/1", if_id_valid, pc, imem_req); end
    endtask

    task automatic test_random();
        logic exp_req;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 8),
                  $urandom, ($urandom_range(0, 99) < 70), $urandom);
            exp_req = m_started && (m_held.size() == 0);
            n_tests++; if (imem_req !== exp_req || imem_addr !== m_pc) begin
                n_fail++; $display("FAIL rnd_req%0d got=%b/%h exp=%b/%h", i, imem_req, imem_addr, exp_req, m_pc); end
            tick();
            n_tests++; if (pc !== m_pc || if_id_valid !== m_valid || if_id_instruction !== m_instr || if_id_pc_plus4 !== m_pc4) begin
                n_fail++; $display("FAIL rnd_state%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", i,
                                   pc, if_id_valid, if_id_instruction, if_id_pc_plus4, m_pc, m_valid, m_instr, m_pc4); end
`ifdef IF_FETCH_COUNT_EN
            n_tests++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, fetch_count, m_count); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        model_reset();

        test_reset();
        test_sequential();
        test_ready_low();
        test_stall_pend();
        test_branch_priority();
        test_wrap();
        test_reset_midop();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
